// File: rtl/ldl_sfifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side streaming stage.
//   BUF_DEPTH   : number of words the output buffer can hold
//   ahead_mode_e: FIFO read timing (show-ahead or one-cycle latent)
//   credit_ok() : true when another FIFO read may be issued without
//                 overrunning the buffer, counting the word still in flight.
package ldl_sfifo_rd_stream_pkg;

    localparam int BUF_DEPTH = 2;

    typedef enum logic {
        MODE_LATENT = 1'b0,   // dout valid the cycle after re
        MODE_AHEAD  = 1'b1    // dout valid in the same cycle as re
    } ahead_mode_e;

    // occ + infl - deq is evaluated in 3 bits so occ=2 plus an in-flight
    // word cannot wrap back to a small value.
    function automatic logic credit_ok(input logic [1:0] occ,
                                       input logic       infl,
                                       input logic       deq);
        logic [2:0] sum;
        sum = {1'b0, occ} + {2'b00, infl} - {2'b00, deq};
        return (sum < 3'(BUF_DEPTH));
    endfunction

endpackage

// File: rtl/ldl_sfifo_rd_stream_regbuf2.sv
// Two-entry in-order register queue. Entry 0 is the head and drives dout
// straight from a flop, so the stream data is registered.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears data and occupancy)
//   clr      : synchronous discard of all held words (data left as is)
//   push/din : append din behind the current contents
//   pop      : remove the head (ignored while empty)
//   dout     : head word
//   occ      : number of words held (0..2)
module ldl_sfifo_rd_stream_regbuf2
    import ldl_sfifo_rd_stream_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [1:0]    occ
);

    logic [BUF_DEPTH-1:0][DW-1:0] ent_reg;
    logic [BUF_DEPTH-1:0][DW-1:0] ent_next;
    logic [BUF_DEPTH-1:0][DW-1:0] shifted;
    logic [1:0]                   occ_reg;
    logic [1:0]                   occ_next;
    logic [1:0]                   slot;
    logic                         pop_eff;

    assign pop_eff  = pop & (occ_reg != 2'd0);
    // Slot the pushed word lands in, after the head has (maybe) moved out.
    // A simultaneous push and pop therefore queues the new word behind
    // the surviving entry and keeps order.
    assign slot     = occ_reg - {1'b0, pop_eff};
    assign occ_next = occ_reg + {1'b0, push} - {1'b0, pop_eff};

    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_ent
            if (gi < BUF_DEPTH - 1) begin : g_mid
                assign shifted[gi] = ent_reg[gi+1];
            end else begin : g_tail
                assign shifted[gi] = ent_reg[gi];
            end
            assign ent_next[gi] = (push && (slot == 2'(gi))) ? din :
                                  (pop_eff ? shifted[gi] : ent_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_reg <= '0;
            occ_reg <= 2'd0;
        end else begin
            ent_reg <= ent_next;
            occ_reg <= clr ? 2'd0 : occ_next;
        end
    end

    assign dout = ent_reg[0];
    assign occ  = occ_reg;

    // A push into a full queue without a pop would lose a word; the
    // upstream credit logic must never allow it.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !clr && !pop_eff && (occ_reg == 2'd2)));

endmodule

// File: rtl/ldl_sfifo_rd_stream.sv
// Read-side stage behind a synchronous FIFO. Turns the FIFO pop interface
// (re/empty/dout) into a registered valid/ready stream at one word per
// cycle, tolerating arbitrary consumer stalls, with a synchronous flush.
// Parameters:
//   DW    : data width (match the FIFO)
//   AHEAD : 1 = FIFO dout valid with re (show-ahead), 0 = one cycle later
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush         : discard buffered words and any read still in flight
//   fifo_empty    : FIFO empty flag
//   fifo_dout     : FIFO read data
//   fifo_re       : FIFO read enable (never high while fifo_empty)
//   m_valid/m_data: registered stream output, head of the buffer
//   m_ready       : consumer accept
//   occ           : words held in the buffer (0..2)
module ldl_sfifo_rd_stream
    import ldl_sfifo_rd_stream_pkg::*;
#(
    parameter int DW    = 8,
    parameter int AHEAD = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_dout,
    output logic          fifo_re,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [1:0]    occ
);

    localparam ahead_mode_e MODE = (AHEAD != 0) ? MODE_AHEAD : MODE_LATENT;

    logic deq;
    logic infl;
    logic push;

    assign m_valid = (occ != 2'd0);
    assign deq     = m_valid & m_ready;

    // Reads are issued on credit: buffered words plus the word still on
    // its way, minus the word leaving this cycle, must stay below the
    // buffer depth. m_ready and fifo_empty reach fifo_re combinationally
    // so a draining consumer keeps the pipe full every cycle.
    assign fifo_re = ~rst & ~flush & ~fifo_empty & credit_ok(occ, infl, deq);

    generate
        if (MODE == MODE_AHEAD) begin : g_ahead
            assign infl = 1'b0;
            assign push = fifo_re;
        end else begin : g_latent
            logic infl_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    infl_reg <= 1'b0;
                end else begin
                    infl_reg <= fifo_re;
                end
            end
            assign infl = infl_reg;
            // Data arriving in a flush cycle belongs to the discarded past.
            assign push = infl_reg & ~flush;
        end
    endgenerate

    ldl_sfifo_rd_stream_regbuf2 #(
        .DW (DW)
    ) u_buf (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .push (push),
        .pop  (deq),
        .din  (fifo_dout),
        .dout (m_data),
        .occ  (occ)
    );

    a_occ_range: assert property (@(posedge clk) disable iff (rst)
        occ <= 2'd2);

endmodule

// File: tb/tb_ldl_sfifo_rd_stream.sv
// Bench: two stages (AHEAD=0 and AHEAD=1), each behind its own small FIFO
// model, driven by the same write/ready/flush stimulus. Words accepted by
// a FIFO are queued as expected beats; a per-instance monitor compares
// every delivered beat and drops words discarded by flush/reset.
module tb_ldl_sfifo_rd_stream;

    localparam int DW = 8;
    localparam int FD = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, flush, fifo_rst, we, m_ready;
    logic [DW-1:0] wdata;

    logic          fifo_empty_w [2];
    logic          fifo_re_w    [2];
    logic          m_valid_w    [2];
    logic [DW-1:0] fifo_dout_w  [2];
    logic [DW-1:0] m_data_w     [2];
    logic [1:0]    occ_w        [2];
    int            qlen         [2];

    int n_vec = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;
    bit verbose = 1'b1;

    task automatic check(input string name, input int k,
                         input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got 0x%0h, required 0x%0h (t=%0t)",
                     name, k, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        logic [DW-1:0] mem [FD];
        logic [4:0]    cnt;
        logic [3:0]    wp, rp;
        logic [DW-1:0] dout_q;
        logic          wr, rd;
        logic [DW-1:0] exp_q [$];

        assign wr = we && (cnt < 5'(FD));
        assign rd = fifo_re_w[gi] && (cnt != 5'd0);
        assign fifo_empty_w[gi] = (cnt == 5'd0);

        if (gi == 1) begin : g_show
            assign fifo_dout_w[gi] = mem[rp];
        end else begin : g_lat
            assign fifo_dout_w[gi] = dout_q;
        end

        always @(posedge clk) begin
            if (fifo_rst) begin
                cnt    <= 5'd0;
                wp     <= 4'd0;
                rp     <= 4'd0;
                dout_q <= '0;
            end else begin
                if (wr) begin
                    mem[wp] <= wdata;
                    wp      <= wp + 4'd1;
                    exp_q.push_back(wdata);
                end
                if (rd) begin
                    dout_q <= mem[rp];
                    rp     <= rp + 4'd1;
                end
                cnt <= cnt + {4'd0, wr} - {4'd0, rd};
            end
        end

        ldl_sfifo_rd_stream #(
            .DW    (DW),
            .AHEAD (gi)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .fifo_empty (fifo_empty_w[gi]),
            .fifo_dout  (fifo_dout_w[gi]),
            .fifo_re    (fifo_re_w[gi]),
            .m_valid    (m_valid_w[gi]),
            .m_ready    (m_ready),
            .m_data     (m_data_w[gi]),
            .occ        (occ_w[gi])
        );

        // Monitor: pend counts words popped from the FIFO but not yet
        // delivered; these are exactly what a flush or reset discards.
        initial begin
            int            pend;
            bit            prev_stall;
            logic [DW-1:0] prev_data;
            logic [DW-1:0] want;
            pend       = 0;
            prev_stall = 1'b0;
            prev_data  = '0;
            qlen[gi]   = 0;
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    check("re_while_empty", gi, 32'(fifo_re_w[gi] & fifo_empty_w[gi]), 32'd0);
                    check("occ_le2", gi, 32'(occ_w[gi] <= 2'd2), 32'd1);
                    check("valid_vs_occ", gi, 32'(m_valid_w[gi]), 32'(occ_w[gi] != 2'd0));
                    if (prev_stall) begin
                        check("hold_valid", gi, 32'(m_valid_w[gi]), 32'd1);
                        check("hold_data", gi, 32'(m_data_w[gi]), 32'(prev_data));
                    end
                    if (m_valid_w[gi] && m_ready) begin
                        if (exp_q.size() == 0) begin
                            check("extra_beat", gi, 32'(m_data_w[gi]), 32'hffff_ffff);
                        end else begin
                            want = exp_q.pop_front();
                            check("beat_data", gi, 32'(m_data_w[gi]), 32'(want));
                            if (verbose)
                                $display("inst%0d beat 0x%02h", gi, m_data_w[gi]);
                        end
                        pend--;
                    end
                    if (fifo_re_w[gi]) pend++;
                    if (flush || rst) begin
                        while (pend > 0 && exp_q.size() > 0) begin
                            want = exp_q.pop_front();
                            pend--;
                        end
                        pend = 0;
                    end
                    prev_stall = m_valid_w[gi] && !m_ready && !flush && !rst;
                    prev_data  = m_data_w[gi];
                    qlen[gi]   = exp_q.size();
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int            beats    [2];
    int            first_v  [2];
    int            last_v   [2];
    int            first_re [2];
    logic [DW-1:0] first_d  [2];

    task automatic observe(input int ncyc);
        for (int k = 0; k < 2; k++) begin
            beats[k] = 0; first_v[k] = -1; last_v[k] = -1;
            first_re[k] = -1; first_d[k] = '0;
        end
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (fifo_re_w[k] && first_re[k] < 0) first_re[k] = i;
                if (m_valid_w[k] && m_ready) begin
                    if (beats[k] == 0) begin
                        first_v[k] = i;
                        first_d[k] = m_data_w[k];
                    end
                    last_v[k] = i;
                    beats[k]++;
                end
            end
        end
    endtask

    task automatic write_seq(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            we    = 1'b1;
            wdata = base + DW'(i);
            step();
        end
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; fifo_rst = 1'b1;
        we = 1'b0; wdata = '0; m_ready = 1'b0;
        step();
        step();
        fifo_rst = 1'b0;
        mon_en   = 1'b1;

        // Reset held while the FIFO fills: nothing may be read or shown.
        write_seq(8'ha1, 8);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check("rst_fifo_re", k, 32'(fifo_re_w[k]), 32'd0);
                check("rst_m_valid", k, 32'(m_valid_w[k]), 32'd0);
                check("rst_m_data", k, 32'(m_data_w[k]), 32'd0);
                check("rst_occ", k, 32'(occ_w[k]), 32'd0);
            end
        end

        // Streaming 0xa1..0xa8 with the consumer always ready.
        step();
        m_ready = 1'b1;
        rst     = 1'b0;
        observe(20);
        for (int k = 0; k < 2; k++) begin
            check("stream_beats", k, 32'(beats[k]), 32'd8);
            check("stream_gapless", k, 32'(last_v[k] - first_v[k]), 32'd7);
            check("stream_latency", k, 32'(first_v[k] - first_re[k]), (k == 1) ? 32'd1 : 32'd2);
        end

        // Back-pressure: 4 words queued, consumer stalled for 5 cycles.
        step();
        m_ready = 1'b0;
        write_seq(8'ha1, 4);
        repeat (5) step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("bp_occ", k, 32'(occ_w[k]), 32'd2);
            check("bp_fifo_re", k, 32'(fifo_re_w[k]), 32'd0);
            check("bp_m_valid", k, 32'(m_valid_w[k]), 32'd1);
            check("bp_m_data", k, 32'(m_data_w[k]), 32'ha1);
        end
        step();
        m_ready = 1'b1;
        observe(10);
        for (int k = 0; k < 2; k++) begin
            check("bp_beats", k, 32'(beats[k]), 32'd4);
            check("bp_gapless", k, 32'(last_v[k] - first_v[k]), 32'd3);
            check("bp_first", k, 32'(first_d[k]), 32'ha1);
        end

        // Empty boundary: one word, then the FIFO runs dry.
        step();
        write_seq(8'h55, 1);
        observe(8);
        for (int k = 0; k < 2; k++) begin
            check("single_beats", k, 32'(beats[k]), 32'd1);
            check("single_data", k, 32'(first_d[k]), 32'h55);
        end

        // Flush one cycle after the read of 0xa3 (AHEAD=0 holds 0xa2 with
        // 0xa3 in flight; AHEAD=1 holds 0xa2,0xa3). Both resume at 0xa4.
        step();
        m_ready = 1'b0;
        write_seq(8'ha1, 5);
        repeat (3) step();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        flush   = 1'b1;
        @(negedge clk);
        check("flush_occ", 0, 32'(occ_w[0]), 32'd1);
        check("flush_occ", 1, 32'(occ_w[1]), 32'd2);
        check("flush_re", 0, 32'(fifo_re_w[0]), 32'd0);
        check("flush_re", 1, 32'(fifo_re_w[1]), 32'd0);
        step();
        flush   = 1'b0;
        m_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check("post_flush_occ", k, 32'(occ_w[k]), 32'd0);
            check("post_flush_valid", k, 32'(m_valid_w[k]), 32'd0);
        end
        observe(8);
        for (int k = 0; k < 2; k++) begin
            check("post_flush_first", k, 32'(first_d[k]), 32'ha4);
            check("post_flush_beats", k, 32'(beats[k]), 32'd2);
        end

        // Random writes, stalls and flushes for 2000 cycles.
        verbose = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            we      = ($urandom_range(0, 1) == 1);
            wdata   = DW'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 39) == 0);
            step();
        end
        we      = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b1;
        repeat (40) step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("drain_left", k, 32'(qlen[k]), 32'd0);
            check("drain_valid", k, 32'(m_valid_w[k]), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
